// File: rtl/cpu_types.sv
// Shared RV32I pipeline types: opcodes, control-bundle encodings and the
// decoded control bundle handed from decode to execute.
package cpu_types;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // PC_JUMP = pc + imm, PC_ALU = ALU result (JALR). With jump_instruction=1
    // the selection only applies when the branch condition holds.
    typedef enum logic [1:0] {PC_PLUS = 2'd0, PC_JUMP = 2'd1, PC_ALU = 2'd2} pc_src_t;
    typedef enum logic [1:0] {SRC1_RS1 = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2} alu_src1_t;
    typedef enum logic       {SRC2_RS2 = 1'b0, SRC2_IMM = 1'b1} alu_src2_t;
    // Encoded like funct3 so OP/OP-IMM decode is a direct copy.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SLL = 3'b001, ALU_SLT = 3'b010, ALU_SLTU = 3'b011,
        ALU_XOR = 3'b100, ALU_SR  = 3'b101, ALU_OR  = 3'b110, ALU_AND  = 3'b111
    } alu_op_t;
    typedef enum logic [1:0] {RD_ALU = 2'd0, RD_MEM = 2'd1, RD_PC4 = 2'd2} rd_src_t;
    typedef enum logic [1:0] {MASK_B = 2'd0, MASK_H = 2'd1, MASK_W = 2'd2} mem_mask_t;

    typedef struct packed {
        logic      memory_we;
        pc_src_t   pc_src;
        logic      jump_instruction;
        logic      jump_negate_zero;   // branch taken when ALU result is non-zero
        alu_src1_t alu_src_1;
        alu_src2_t alu_src_2;
        alu_op_t   alu_op;
        logic      alu_signed;         // SLT signed compare / arithmetic right shift
        logic      alu_negate;         // invert operand 2 ...
        logic      alu_add_one;        // ... plus carry-in: subtraction
        logic [4:0] reg_rs1;
        logic [4:0] reg_rs2;
        rd_src_t   reg_rd_src;
        logic [4:0] reg_rd;
        logic      reg_we;
        mem_mask_t memory_mask;
        logic      memory_sign_extension;
    } decode_ctrl_t;

    // Reset / bubble bundle: no writes, sequential PC.
    localparam decode_ctrl_t DECODE_CTRL_NOP = '0;

endpackage

// File: rtl/decode_stage_instruction_decoder.sv
// Combinational RV32I decoder: instruction word -> control bundle,
// sign-extended immediate and illegal flag.
module instruction_decoder
    import cpu_types::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic [31:0]     instruction_i,
    output decode_ctrl_t    ctrl_o,
    output logic [XLEN-1:0] immediate_o,
    output logic            illegal_o
);

    logic [31:0] i;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;

    assign i   = instruction_i;
    assign opc = i[6:0];
    assign f3  = i[14:12];
    assign f7  = i[31:25];
    assign rs1 = i[19:15];
    assign rs2 = i[24:20];
    assign rd  = i[11:7];

    logic signed [31:0] imm32;
    logic               use_rs1, use_rs2, use_rd, bad_enc, bad_reg;
    decode_ctrl_t       c;

    // Per-opcode decode, then register-range check and illegal squash
    always_comb begin
        c       = DECODE_CTRL_NOP;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        bad_enc = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                imm32       = {i[31:12], 12'b0};
                use_rd      = 1'b1;
                c.alu_src_1 = (opc == OPC_LUI) ? SRC1_ZERO : SRC1_PC;
                c.alu_src_2 = SRC2_IMM;
                c.reg_we    = 1'b1;
            end
            OPC_JAL: begin
                imm32        = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                use_rd       = 1'b1;
                c.pc_src     = PC_JUMP;
                c.reg_rd_src = RD_PC4;
                c.reg_we     = 1'b1;
            end
            OPC_JALR: begin
                imm32        = {{20{i[31]}}, i[31:20]};
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                c.pc_src     = PC_ALU;
                c.alu_src_2  = SRC2_IMM;
                c.reg_rd_src = RD_PC4;
                c.reg_we     = 1'b1;
                bad_enc      = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm32              = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                c.pc_src           = PC_JUMP;
                c.jump_instruction = 1'b1;
                // beq/bge/bgeu branch on zero, bne/blt/bltu on non-zero
                c.jump_negate_zero = f3[0] ^ f3[2];
                if (f3[2]) begin
                    c.alu_op     = f3[1] ? ALU_SLTU : ALU_SLT;
                    c.alu_signed = ~f3[1];
                end else begin
                    c.alu_negate  = 1'b1;
                    c.alu_add_one = 1'b1;
                end
                bad_enc = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                imm32                   = {{20{i[31]}}, i[31:20]};
                use_rs1                 = 1'b1;
                use_rd                  = 1'b1;
                c.alu_src_2             = SRC2_IMM;
                c.reg_rd_src            = RD_MEM;
                c.reg_we                = 1'b1;
                c.memory_mask           = mem_mask_t'(f3[1:0]);
                c.memory_sign_extension = ~f3[2];
                bad_enc                 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm32         = {{20{i[31]}}, i[31:25], i[11:7]};
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                c.alu_src_2   = SRC2_IMM;
                c.memory_we   = 1'b1;
                c.memory_mask = mem_mask_t'(f3[1:0]);
                bad_enc       = (f3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                imm32        = {{20{i[31]}}, i[31:20]};
                use_rs1      = 1'b1;
                use_rd       = 1'b1;
                c.alu_src_2  = SRC2_IMM;
                c.alu_op     = alu_op_t'(f3);
                c.alu_signed = (f3 == 3'b010) || (f3 == 3'b101 && i[30]);
                c.reg_we     = 1'b1;
            end
            OPC_OP: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                use_rd        = 1'b1;
                c.alu_op      = alu_op_t'(f3);
                c.alu_signed  = (f3 == 3'b010) || (f3 == 3'b101 && i[30]);
                c.alu_negate  = (f3 == 3'b000) && i[30];
                c.alu_add_one = (f3 == 3'b000) && i[30];
                c.reg_we      = 1'b1;
                bad_enc       = !((f7 == 7'b0000000) ||
                                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            default: bad_enc = 1'b1;
        endcase

        bad_reg = (use_rs1 && int'(rs1) >= NUM_REGS) ||
                  (use_rs2 && int'(rs2) >= NUM_REGS) ||
                  (use_rd  && int'(rd)  >= NUM_REGS);

        // Unused fields read as 0 so hazard logic sees no false dependencies
        c.reg_rs1 = use_rs1 ? rs1 : 5'd0;
        c.reg_rs2 = use_rs2 ? rs2 : 5'd0;
        c.reg_rd  = use_rd  ? rd  : 5'd0;

        if (bad_enc || bad_reg) begin
            c.reg_we           = 1'b0;
            c.memory_we        = 1'b0;
            c.jump_instruction = 1'b0;
            c.pc_src           = PC_PLUS;
        end
    end

    assign ctrl_o      = c;
    assign illegal_o   = bad_enc || bad_reg;
    assign immediate_o = XLEN'(imm32);   // signed source: sign-extends to XLEN

endmodule

// File: rtl/decode_stage.sv
// Registered valid/ready decode stage with optional 2-entry skid buffer.
// Decode happens on the input side; the main entry drives the outputs.
module decode_stage
    import cpu_types::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int SKID_EN  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_immediate,
    output decode_ctrl_t    out_ctrl,
    output logic            out_illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            rdy_q;
    logic            in_xfer, out_xfer, ld_dec, ld_skid, mv_skid;

    decode_ctrl_t    dec_ctrl, main_ctrl_q, skid_ctrl_q;
    logic [XLEN-1:0] dec_imm, main_imm_q, skid_imm_q, main_pc_q, skid_pc_q;
    logic            dec_ill, main_ill_q, skid_ill_q;

    instruction_decoder #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_dec (
        .instruction_i (in_instruction),
        .ctrl_o        (dec_ctrl),
        .immediate_o   (dec_imm),
        .illegal_o     (dec_ill)
    );

    assign out_valid     = (state_q != ST_EMPTY);
    assign out_pc        = main_pc_q;
    assign out_immediate = main_imm_q;
    assign out_ctrl      = main_ctrl_q;
    assign out_illegal   = main_ill_q;
    assign out_xfer      = out_valid && out_ready;
    assign in_xfer       = in_valid && in_ready;

    // Ready: registered !FULL with skid, pass-through backpressure without; never during flush
    always_comb begin
        if (SKID_EN != 0) in_ready = rdy_q && !flush;
        else              in_ready = rdy_q && !flush && (!out_valid || out_ready);
    end

    // Buffer occupancy FSM; flush overrides every transition
    always_comb begin
        state_d = state_q;
        ld_dec  = 1'b0;
        ld_skid = 1'b0;
        mv_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) begin
                    state_d = ST_ONE;
                    ld_dec  = 1'b1;
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = ST_FULL;
                        ld_skid = 1'b1;
                    end else if (in_xfer) begin
                        ld_dec = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (out_xfer) begin
                    state_d = ST_ONE;
                    mv_skid = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and ready flag; ready stays low until the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_FULL);
        end
    end

    // Main entry: fresh decode or promoted skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= DECODE_CTRL_NOP;
            main_imm_q  <= '0;
            main_pc_q   <= '0;
            main_ill_q  <= 1'b0;
        end else if (ld_dec) begin
            main_ctrl_q <= dec_ctrl;
            main_imm_q  <= dec_imm;
            main_pc_q   <= in_pc;
            main_ill_q  <= dec_ill;
        end else if (mv_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_imm_q  <= skid_imm_q;
            main_pc_q   <= skid_pc_q;
            main_ill_q  <= skid_ill_q;
        end
    end

    // Skid entry: catches the accept made while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl_q <= DECODE_CTRL_NOP;
            skid_imm_q  <= '0;
            skid_pc_q   <= '0;
            skid_ill_q  <= 1'b0;
        end else if (ld_skid) begin
            skid_ctrl_q <= dec_ctrl;
            skid_imm_q  <= dec_imm;
            skid_pc_q   <= in_pc;
            skid_ill_q  <= dec_ill;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: DUT a = RV32I defaults with skid buffer, DUT b = XLEN 64,
// RV32E register file, single entry. Both share the input stream.
module tb_decode_stage;
    import cpu_types::*;

    logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instruction = '0, in_pc = '0;

    logic a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_pc, a_out_imm;
    decode_ctrl_t a_ctrl;
    logic b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_pc, b_out_imm;
    decode_ctrl_t b_ctrl;

    int n_cmp = 0, n_bad = 0;

    logic [31:0] ADDI, BEQ, ADD17, BADOPC, LDBAD, OPBAD, LUI, SW, MARK;

    decode_stage #(.XLEN(32), .NUM_REGS(32), .SKID_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_out_pc), .out_immediate(a_out_imm),
        .out_ctrl(a_ctrl), .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(64), .NUM_REGS(16), .SKID_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instruction(in_instruction), .in_pc({32'h0, in_pc}), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .out_immediate(b_out_imm),
        .out_ctrl(b_ctrl), .out_illegal(b_out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ADDI   = 32'h11110093;                                           // addi x1,x2,0x111
        BEQ    = {7'b1100000, 5'd1, 5'd2, 3'b000, 5'b00011, 7'b1100011};
        ADD17  = {7'b0, 5'd3, 5'd2, 3'b000, 5'd17, 7'b0110011};          // add x17,x2,x3
        BADOPC = 32'h0000007F;
        LDBAD  = {12'h0, 5'd1, 3'b011, 5'd2, 7'b0000011};                // load funct3 011
        OPBAD  = {7'b0100000, 5'd3, 5'd2, 3'b001, 5'd1, 7'b0110011};     // funct7 0100000 + sll
        LUI    = {20'hA000A, 5'd1, 7'b0110111};
        SW     = {7'b0, 5'd3, 5'd2, 3'b010, 5'd8, 7'b0100011};           // sw x3,8(x2)
        MARK   = 32'h55500293;                                           // addi x5,x0,0x555

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst valid", a_out_valid, 0);
        chk("rst ready", a_in_ready, 0);
        chk("rst ctrl",  64'(a_ctrl), 64'(DECODE_CTRL_NOP));
        chk("rst pc",    a_out_pc, 0);
        chk("rst imm",   a_out_imm, 0);
        chk("rst ill",   a_out_illegal, 0);
        #9 rst_n = 1'b1;
        cyc;
        chk("ready a after rst", a_in_ready, 1);
        chk("ready b after rst", b_in_ready, 1);

        // streaming decode, out_ready held high
        in_valid = 1'b1; out_ready = 1'b1; in_instruction = ADDI; in_pc = 32'h100;
        cyc;
        chk("addi valid", a_out_valid, 1);
        chk("addi imm",   a_out_imm, 32'h111);
        chk("addi rs1",   a_ctrl.reg_rs1, 2);
        chk("addi rd",    a_ctrl.reg_rd, 1);
        chk("addi we",    a_ctrl.reg_we, 1);
        chk("addi ill",   a_out_illegal, 0);
        chk("addi pc",    a_out_pc, 32'h100);
        chk("addi b imm", b_out_imm, 64'h111);

        in_instruction = BEQ; in_pc = 32'h104;
        cyc;
        chk("beq imm",   a_out_imm, 32'hFFFFFC02);
        chk("beq jump",  a_ctrl.jump_instruction, 1);
        chk("beq we",    a_ctrl.reg_we, 0);
        chk("beq pcsrc", a_ctrl.pc_src, PC_JUMP);
        chk("beq b imm", b_out_imm, 64'hFFFFFFFFFFFFFC02);
        chk("beq b pc",  b_out_pc, 64'h104);

        in_instruction = ADD17; in_pc = 32'h108;
        cyc;
        chk("add17 a ill", a_out_illegal, 0);
        chk("add17 a rd",  a_ctrl.reg_rd, 17);
        chk("add17 a we",  a_ctrl.reg_we, 1);
        chk("add17 b ill", b_out_illegal, 1);
        chk("add17 b we",  b_ctrl.reg_we, 0);
        chk("add17 b vld", b_out_valid, 1);

        in_instruction = BADOPC; in_pc = 32'h10C;
        cyc;
        chk("badopc a ill", a_out_illegal, 1);
        chk("badopc a vld", a_out_valid, 1);
        chk("badopc a we",  a_ctrl.reg_we, 0);
        chk("badopc b ill", b_out_illegal, 1);

        in_instruction = LDBAD;
        cyc;
        chk("ld f3 ill", a_out_illegal, 1);
        in_instruction = OPBAD;
        cyc;
        chk("op f7 ill", a_out_illegal, 1);

        in_valid = 1'b0;
        cyc;
        chk("drain a vld", a_out_valid, 0);
        chk("drain b vld", b_out_valid, 0);

        // backpressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_instruction = LUI; in_pc = 32'h200;
        cyc;
        chk("bp lui vld",   a_out_valid, 1);
        chk("bp lui imm",   a_out_imm, 32'hA000A000);
        chk("bp rdy1",      a_in_ready, 1);
        chk("bp b rdy",     b_in_ready, 0);
        in_instruction = SW; in_pc = 32'h204;
        cyc;
        chk("bp full rdy",  a_in_ready, 0);
        chk("bp hold imm",  a_out_imm, 32'hA000A000);
        chk("bp hold pc",   a_out_pc, 32'h200);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc;
        chk("bp sw imm",    a_out_imm, 32'h8);
        chk("bp sw mwe",    a_ctrl.memory_we, 1);
        chk("bp sw pc",     a_out_pc, 32'h204);
        chk("bp rdy again", a_in_ready, 1);
        cyc;
        chk("bp empty",     a_out_valid, 0);

        // flush while full
        out_ready = 1'b0; in_valid = 1'b1; in_instruction = ADDI; in_pc = 32'h300;
        cyc;
        in_instruction = BEQ; in_pc = 32'h304;
        cyc;
        chk("fl full rdy", a_in_ready, 0);
        flush = 1'b1; in_instruction = MARK; in_pc = 32'h308;
        #1;
        chk("fl rdy a", a_in_ready, 0);
        chk("fl rdy b", b_in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("fl vld a", a_out_valid, 0);
        chk("fl rdy post", a_in_ready, 1);
        chk("fl vld b", b_out_valid, 0);
        cyc;
        chk("fl dropped", a_out_valid, 0);

        // asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b0; in_instruction = ADDI; in_pc = 32'h400;
        cyc;
        chk("ar pre vld", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar vld",   a_out_valid, 0);
        chk("ar ctrl",  64'(a_ctrl), 64'(DECODE_CTRL_NOP));
        chk("ar rdy",   a_in_ready, 0);
        chk("ar pc",    a_out_pc, 0);
        chk("ar b vld", b_out_valid, 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
